// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and burst helpers for the burst address generator.
package ahb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    typedef enum logic [1:0] {
        TR_IDLE   = IDLE,
        TR_BUSY   = BUSY,
        TR_NONSEQ = NONSEQ,
        TR_SEQ    = SEQ
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_t;

    function automatic logic [7:0] beats_of(hburst_t burst, logic [7:0] len);
        case (burst)
            BURST_SINGLE:              beats_of = 8'd1;
            BURST_INCR:                beats_of = (len == 8'd0) ? 8'd1 : len;
            BURST_WRAP4, BURST_INCR4:  beats_of = 8'd4;
            BURST_WRAP8, BURST_INCR8:  beats_of = 8'd8;
            default:                   beats_of = 8'd16;
        endcase
    endfunction

    function automatic logic is_wrap(hburst_t burst);
        return (burst == BURST_WRAP4) || (burst == BURST_WRAP8) || (burst == BURST_WRAP16);
    endfunction

    function automatic logic is_fixed_incr(hburst_t burst);
        return (burst == BURST_INCR4) || (burst == BURST_INCR8) || (burst == BURST_INCR16);
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen_if.sv
// Command and AHB address-phase signals of the burst generator; master = generator side.
interface ahb_burst_addr_gen_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic        cmd_write;
    logic [7:0]  cmd_len;
    logic        stall_req;
    logic        h_ready;
    logic        h_resp;
    logic [1:0]  h_trans;
    logic [31:0] h_addr;
    logic [2:0]  h_burst;
    logic [2:0]  h_size;
    logic        h_write;
    logic        done;
    logic        cmd_err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
        input  stall_req, h_ready, h_resp,
        output cmd_ready, h_trans, h_addr, h_burst, h_size, h_write, done, cmd_err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
        output stall_req, h_ready, h_resp,
        input  cmd_ready, h_trans, h_addr, h_burst, h_size, h_write, done, cmd_err
    );

endinterface

// File: rtl/ahb_burst_addr_calc.sv
// Combinational next-beat address for INCR/WRAP bursts, plus the 1 KB landing flag.
module ahb_burst_addr_calc
    import ahb_pkg::*;
(
    input  logic [31:0] addr,
    input  hburst_t     burst,
    input  logic [2:0]  size,
    input  logic [7:0]  n,
    output logic [31:0] next_addr,
    output logic        cross_1k
);

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        incr_addr = addr + (32'd1 << size);
        wrap_mask = (32'(n) << size) - 32'd1;
        next_addr = is_wrap(burst) ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
        // Wrapping bursts stay inside their aligned window, so only incrementing ones re-arbitrate.
        cross_1k  = !is_wrap(burst) && (next_addr[9:0] == 10'd0);
    end

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// AHB-Lite burst address/control phase generator: NONSEQ/SEQ/BUSY sequencing, HREADY stalls, ERROR abort.
module ahb_burst_addr_gen
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_INCR_LEN = 255
)
(
    input  logic                 h_clk,
    input  logic                 h_resetn,
    ahb_burst_addr_gen_if.master bus
);

    typedef enum logic [2:0] {ST_IDLE, ST_FIRST, ST_NEXT, ST_BUSY, ST_ABORT} state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_INCR_LEN);

    state_t      state_q, state_d;
    htrans_t     h_trans_q, h_trans_d;
    logic [31:0] h_addr_q, h_addr_d;
    hburst_t     h_burst_q, h_burst_d;
    logic [2:0]  h_size_q, h_size_d;
    logic        h_write_q, h_write_d;
    logic [7:0]  rem_q, rem_d;
    logic        done_q, done_d;
    logic        cmd_err_q, cmd_err_d;

    hburst_t     cmd_burst;
    logic [7:0]  cmd_len_c;
    logic [7:0]  cmd_n;
    logic [31:0] cmd_span;
    logic        cmd_bad;
    logic        cmd_ready;
    logic        cmd_accept;
    logic        last_beat;
    logic        err_hit;
    logic        resume_cross;
    logic [7:0]  cur_n;
    logic [31:0] next_addr;
    logic        next_cross;

    assign cmd_burst = hburst_t'(bus.cmd_burst);
    assign cmd_len_c = ({1'b0, bus.cmd_len} > {1'b0, MAX_LEN}) ? MAX_LEN : bus.cmd_len;
    assign cmd_n     = beats_of(cmd_burst, cmd_len_c);
    assign cmd_span  = {22'd0, bus.cmd_addr[9:0]} + (32'(cmd_n) << bus.cmd_size);
    assign cmd_bad   = (bus.cmd_size > 3'd2)
                     || ((bus.cmd_size == 3'd1) && bus.cmd_addr[0])
                     || ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] != 2'd0))
                     || (is_fixed_incr(cmd_burst) && (cmd_span > 32'd1024));

    // A new command may be taken in the same cycle the final beat is accepted, giving back-to-back bursts.
    assign last_beat    = ((state_q == ST_FIRST) || (state_q == ST_NEXT)) && (rem_q == 8'd0);
    assign cmd_ready    = (state_q == ST_IDLE) || (last_beat && bus.h_ready && !bus.h_resp);
    assign cmd_accept   = bus.cmd_valid && cmd_ready;
    assign err_hit      = bus.h_resp && !bus.h_ready;
    assign resume_cross = (h_addr_q[9:0] == 10'd0) && !is_wrap(h_burst_q);
    assign cur_n        = beats_of(h_burst_q, 8'd1);

    ahb_burst_addr_calc u_calc (
        .addr      (h_addr_q),
        .burst     (h_burst_q),
        .size      (h_size_q),
        .n         (cur_n),
        .next_addr (next_addr),
        .cross_1k  (next_cross)
    );

    always_comb begin
        state_d   = state_q;
        h_trans_d = TR_IDLE;
        h_addr_d  = h_addr_q;
        h_burst_d = h_burst_q;
        h_size_d  = h_size_q;
        h_write_d = h_write_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;

        case (state_q)
            ST_FIRST, ST_NEXT: begin
                if (err_hit) begin
                    state_d   = ST_ABORT;
                    cmd_err_d = 1'b1;
                end else if (bus.h_ready) begin
                    if (rem_q == 8'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        h_addr_d = next_addr;
                        rem_d    = rem_q - 8'd1;
                        if (bus.stall_req)   state_d = ST_BUSY;
                        else if (next_cross) state_d = ST_FIRST;
                        else                 state_d = ST_NEXT;
                    end
                end
            end
            ST_BUSY: begin
                if (err_hit) begin
                    state_d   = ST_ABORT;
                    cmd_err_d = 1'b1;
                end else if (bus.h_ready && !bus.stall_req) begin
                    state_d = resume_cross ? ST_FIRST : ST_NEXT;
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default: ;
        endcase

        if (cmd_accept) begin
            if (cmd_bad) begin
                cmd_err_d = 1'b1;
            end else begin
                state_d   = ST_FIRST;
                h_addr_d  = bus.cmd_addr;
                h_burst_d = cmd_burst;
                h_size_d  = bus.cmd_size;
                h_write_d = bus.cmd_write;
                rem_d     = cmd_n - 8'd1;
            end
        end

        case (state_d)
            ST_FIRST: h_trans_d = TR_NONSEQ;
            ST_NEXT:  h_trans_d = TR_SEQ;
            ST_BUSY:  h_trans_d = TR_BUSY;
            default:  h_trans_d = TR_IDLE;
        endcase
    end

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state_q   <= ST_IDLE;
            h_trans_q <= TR_IDLE;
            h_addr_q  <= 32'd0;
            h_burst_q <= BURST_SINGLE;
            h_size_q  <= 3'd0;
            h_write_q <= 1'b0;
            rem_q     <= 8'd0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_trans_q <= h_trans_d;
            h_addr_q  <= h_addr_d;
            h_burst_q <= h_burst_d;
            h_size_q  <= h_size_d;
            h_write_q <= h_write_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.h_trans   = h_trans_q;
    assign bus.h_addr    = h_addr_q;
    assign bus.h_burst   = h_burst_q;
    assign bus.h_size    = h_size_q;
    assign bus.h_write   = h_write_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Bench for ahb_burst_addr_gen: directed burst scenarios plus randomized traffic against a beat-index reference model.
module tb_ahb_burst_addr_gen;

    logic h_clk = 1'b0;
    logic h_resetn = 1'b0;
    always #5 h_clk = ~h_clk;

    ahb_burst_addr_gen_if bus_if();

    ahb_burst_addr_gen #(.MAX_INCR_LEN(255)) dut (
        .h_clk    (h_clk),
        .h_resetn (h_resetn),
        .bus      (bus_if.master)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 transfer phase, 2 busy phase, 3 abort.
    int          mk, mbeat, mn;
    logic [31:0] mstart;
    int          mburst, msize;
    logic        mwrite;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic [2:0]  e_burst, e_size;
    logic        e_write, e_done, e_err;

    function automatic int beats(input int b, input int len);
        case (b)
            0:       return 1;
            1:       return (len == 0) ? 1 : len;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic legal(input int b, input int s, input logic [31:0] a, input int len);
        if (s > 2) return 1'b0;
        if ((a % (32'd1 << s)) != 0) return 1'b0;
        if ((b == 3 || b == 5 || b == 7) && ((a % 1024) + beats(b, len) * (1 << s)) > 1024) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] beat_addr(input int k);
        int unsigned bytes, span, off;
        bytes = 32'd1 << msize;
        if (mburst == 2 || mburst == 4 || mburst == 6) begin
            span = mn * bytes;
            off  = mstart % span;
            return mstart - off + (off + k * bytes) % span;
        end
        return mstart + k * bytes;
    endfunction

    function automatic logic [1:0] seq_code(input int k, input logic [31:0] a);
        return (k == 0 || (mburst == 1 && a[9:0] == 10'd0)) ? 2'd2 : 2'd3;
    endfunction

    task automatic model_reset();
        mk = 0; mbeat = 0; mn = 1; mstart = 0; mburst = 0; msize = 0; mwrite = 0;
        e_trans = 0; e_addr = 0; e_burst = 0; e_size = 0; e_write = 0; e_done = 0; e_err = 0;
    endtask

    task automatic drive_idle();
        bus_if.cmd_valid = 0; bus_if.cmd_addr = 0; bus_if.cmd_burst = 0; bus_if.cmd_size = 0;
        bus_if.cmd_write = 0; bus_if.cmd_len = 0; bus_if.stall_req = 0;
        bus_if.h_ready = 1; bus_if.h_resp = 0;
    endtask

    // Check current outputs mid-cycle, advance the model by one clock edge, return at edge+1.
    task automatic step();
        logic rdy;
        @(negedge h_clk);
        rdy = (mk == 0) || (mk == 1 && mbeat == mn - 1 && bus_if.h_ready && !bus_if.h_resp);
        chk("h_trans", bus_if.h_trans, e_trans);
        chk("h_addr", bus_if.h_addr, e_addr);
        chk("h_burst", bus_if.h_burst, e_burst);
        chk("h_size", bus_if.h_size, e_size);
        chk("h_write", bus_if.h_write, e_write);
        chk("done", bus_if.done, e_done);
        chk("cmd_err", bus_if.cmd_err, e_err);
        chk("cmd_ready", bus_if.cmd_ready, rdy);
        e_done = 0;
        e_err  = 0;
        if (mk == 1 || mk == 2) begin
            if (bus_if.h_resp && !bus_if.h_ready) begin
                mk = 3; e_trans = 0; e_err = 1;
            end else if (bus_if.h_ready) begin
                if (mk == 1) begin
                    if (mbeat == mn - 1) begin
                        mk = 0; e_trans = 0; e_done = 1;
                    end else begin
                        mbeat++;
                        e_addr = beat_addr(mbeat);
                        if (bus_if.stall_req) begin mk = 2; e_trans = 2'd1; end
                        else e_trans = seq_code(mbeat, e_addr);
                    end
                end else if (!bus_if.stall_req) begin
                    mk = 1; e_trans = seq_code(mbeat, e_addr);
                end
            end
        end else if (mk == 3) begin
            mk = 0; e_trans = 0;
        end
        if (bus_if.cmd_valid && rdy) begin
            if (legal(bus_if.cmd_burst, bus_if.cmd_size, bus_if.cmd_addr, bus_if.cmd_len)) begin
                mk = 1; mbeat = 0;
                mburst = bus_if.cmd_burst; msize = bus_if.cmd_size; mwrite = bus_if.cmd_write;
                mstart = bus_if.cmd_addr; mn = beats(mburst, bus_if.cmd_len);
                e_trans = 2'd2; e_addr = mstart; e_burst = bus_if.cmd_burst;
                e_size = bus_if.cmd_size; e_write = mwrite;
            end else begin
                e_err = 1;
            end
        end
        @(posedge h_clk);
        #1;
    endtask

    task automatic issue(input int b, input int s, input logic [31:0] a, input int len, input logic w);
        bus_if.cmd_valid = 1; bus_if.cmd_burst = 3'(b); bus_if.cmd_size = 3'(s);
        bus_if.cmd_addr = a; bus_if.cmd_len = 8'(len); bus_if.cmd_write = w;
        step();
        bus_if.cmd_valid = 0;
    endtask

    logic [31:0] wrap_exp [3] = '{32'h3C, 32'h30, 32'h34};
    logic [31:0] cross_addr [3] = '{32'h3FC, 32'h400, 32'h404};
    logic [1:0]  cross_tr [3] = '{2'd3, 2'd2, 2'd3};

    initial begin
        int held, sz, r, err2;
        logic [31:0] last, a;

        drive_idle();
        model_reset();
        @(posedge h_clk); #1;
        chk("rst_trans", bus_if.h_trans, 0);
        chk("rst_addr", bus_if.h_addr, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_ready", bus_if.cmd_ready, 1);
        @(posedge h_clk); #1;
        h_resetn = 1;

        // WRAP4 at 0x38
        issue(2, 2, 32'h38, 0, 0);
        chk("wrap4_b0_tr", bus_if.h_trans, 2);
        chk("wrap4_b0_ad", bus_if.h_addr, 32'h38);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap4_tr", bus_if.h_trans, 3);
            chk("wrap4_ad", bus_if.h_addr, wrap_exp[i]);
        end
        step();
        chk("wrap4_done", bus_if.done, 1);
        step();
        chk("wrap4_done_once", bus_if.done, 0);

        // INCR8 with a 3-cycle HREADY stall at beat 3
        issue(5, 1, 32'h100, 0, 1);
        held = 0; last = 0;
        for (int i = 0; i < 14; i++) begin
            bus_if.h_ready = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            step();
            if (bus_if.h_trans != 2'd0) begin
                if (bus_if.h_addr == 32'h104) held++;
                last = bus_if.h_addr;
            end
        end
        bus_if.h_ready = 1;
        chk("incr8_hold", held, 4);
        chk("incr8_last", last, 32'h10E);

        // INCR len 4 crossing 1 KB
        issue(1, 2, 32'h3F8, 4, 0);
        chk("x1k_b0_tr", bus_if.h_trans, 2);
        chk("x1k_b0_ad", bus_if.h_addr, 32'h3F8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("x1k_tr", bus_if.h_trans, cross_tr[i]);
            chk("x1k_ad", bus_if.h_addr, cross_addr[i]);
        end
        step();
        chk("x1k_done", bus_if.done, 1);

        // INCR4 with BUSY insertion before beat 2
        issue(3, 2, 32'h0, 0, 0);
        bus_if.stall_req = 1;
        step();
        chk("busy1_tr", bus_if.h_trans, 1);
        chk("busy1_ad", bus_if.h_addr, 32'h4);
        step();
        chk("busy2_tr", bus_if.h_trans, 1);
        bus_if.stall_req = 0;
        step();
        chk("busy_seq_tr", bus_if.h_trans, 3);
        chk("busy_seq_ad", bus_if.h_addr, 32'h4);
        step(); step(); step();
        chk("busy_done", bus_if.done, 1);

        // INCR16 crossing 1 KB is rejected
        issue(7, 2, 32'h3F0, 0, 0);
        chk("rej_err", bus_if.cmd_err, 1);
        chk("rej_tr", bus_if.h_trans, 0);
        step();
        chk("rej_err_pulse", bus_if.cmd_err, 0);

        // ERROR response at beat 2 of INCR8
        issue(5, 2, 32'h200, 0, 0);
        step();
        bus_if.h_ready = 0; bus_if.h_resp = 1;
        step();
        chk("abort_tr", bus_if.h_trans, 0);
        chk("abort_err", bus_if.cmd_err, 1);
        chk("abort_done", bus_if.done, 0);
        bus_if.h_ready = 1;
        step();
        bus_if.h_resp = 0;
        step();

        // Reset in the middle of WRAP8
        issue(4, 2, 32'h10, 0, 0);
        step(); step();
        #2 h_resetn = 0;
        #1;
        chk("mrst_trans", bus_if.h_trans, 0);
        chk("mrst_addr", bus_if.h_addr, 0);
        chk("mrst_burst", bus_if.h_burst, 0);
        chk("mrst_size", bus_if.h_size, 0);
        chk("mrst_done", bus_if.done, 0);
        model_reset();
        @(posedge h_clk); #1;
        h_resetn = 1;
        chk("mrst_ready", bus_if.cmd_ready, 1);
        step();

        // Randomized traffic
        err2 = 0;
        for (int c = 0; c < 3000; c++) begin
            bus_if.cmd_valid = ($urandom % 3 == 0);
            bus_if.cmd_burst = 3'($urandom % 8);
            sz = ($urandom % 12 == 0) ? int'(3 + $urandom % 5) : int'($urandom % 3);
            bus_if.cmd_size = 3'(sz);
            r = int'($urandom % 4);
            a = ($urandom & 32'hFFFF_F000) | ((r == 0) ? (32'h3C0 + $urandom % 64) : ($urandom % 1024));
            if ($urandom % 8 != 0) a = a & ~((32'd1 << sz) - 32'd1);
            bus_if.cmd_addr  = a;
            bus_if.cmd_len   = ($urandom % 16 == 0) ? 8'($urandom % 256) : 8'($urandom % 12);
            bus_if.cmd_write = 1'($urandom % 2);
            bus_if.stall_req = ($urandom % 4 == 0);
            if (err2 != 0) begin
                bus_if.h_ready = 1; bus_if.h_resp = 1; err2 = 0;
            end else if ($urandom % 40 == 0) begin
                bus_if.h_ready = 0; bus_if.h_resp = 1; err2 = 1;
            end else begin
                bus_if.h_resp = 0; bus_if.h_ready = ($urandom % 5 != 0);
            end
            step();
        end
        drive_idle();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
